// File: rtl/gnrl_skid_buf_if.sv
// Valid/ready channel bundle for the two-entry skid buffer.
// The slave modport is the buffer's own view; the master modport is the view of the logic around it.
interface gnrl_skid_buf_if #(
    parameter int unsigned DW = 32
) ();
    logic          i_vld;
    logic          i_rdy;
    logic [DW-1:0] i_dat;
    logic          o_vld;
    logic          o_rdy;
    logic [DW-1:0] o_dat;
    logic [1:0]    cnt;

    modport slave (
        input  i_vld, i_dat, o_rdy,
        output i_rdy, o_vld, o_dat, cnt
    );

    modport master (
        output i_vld, i_dat, o_rdy,
        input  i_rdy, o_vld, o_dat, cnt
    );
endinterface

// File: rtl/gnrl_skid_buf.sv
// Two-entry registered skid buffer: valid, ready, data and occupancy all come straight from flops.
// The main register drives o_dat; the skid register catches one beat while the sink stalls.
module gnrl_skid_buf #(
    parameter int unsigned DW = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    gnrl_skid_buf_if.slave      bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] main_q, main_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          i_rdy_q;
    logic          o_vld_q;

    // Next state and data steering; flush forces EMPTY and freezes both data registers.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (bus.i_vld) begin
                    main_d  = bus.i_dat;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                case ({bus.i_vld, bus.o_rdy})
                    2'b11: main_d = bus.i_dat;
                    2'b10: begin
                        skid_d  = bus.i_dat;
                        state_d = FULL;
                    end
                    2'b01: state_d = EMPTY;
                    default: ;
                endcase
            end
            FULL: begin
                if (bus.o_rdy) begin
                    main_d  = skid_q;
                    state_d = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    // Handshake outputs are decoded from the next state so they sit in their own flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            i_rdy_q <= 1'b1;
            o_vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            i_rdy_q <= (state_d != FULL);
            o_vld_q <= (state_d != EMPTY);
        end
    end

    assign bus.i_rdy = i_rdy_q;
    assign bus.o_vld = o_vld_q;
    assign bus.o_dat = main_q;
    assign bus.cnt   = 2'(state_q);
endmodule

// File: tb/tb_gnrl_skid_buf.sv
// Scoreboard bench for gnrl_skid_buf: accepted beats are queued, delivered beats are popped and compared,
// and occupancy/handshake flags are checked every cycle against the queue depth.
module tb_gnrl_skid_buf;
    localparam int unsigned DW = 32;

    logic clk;
    logic rst;
    logic flush;

    gnrl_skid_buf_if #(.DW(DW)) bus ();

    gnrl_skid_buf #(.DW(DW)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned total;
    int unsigned bad;
    logic [DW-1:0] sb[$];

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs; they are sampled at the following rising edge.
    task automatic cyc(input logic r, input logic f, input logic v, input logic [DW-1:0] d, input logic ordy);
        @(negedge clk);
        rst       = r;
        flush     = f;
        bus.i_vld = v;
        bus.i_dat = d;
        bus.o_rdy = ordy;
    endtask

    // Look at o_dat right after the edge that consumed the last driven cycle.
    task automatic peek(input string tag, input logic [DW-1:0] exp);
        @(posedge clk);
        #1;
        chk(tag, bus.o_dat, exp);
    endtask

    // Monitor: inputs were driven at the negedge, so #1 later the upcoming edge's handshake is known.
    always @(negedge clk) begin
        logic [DW-1:0] exp;
        #1;
        if (rst) begin
            sb.delete();
        end else begin
            chk("cnt",   DW'(bus.cnt),   DW'(sb.size()));
            chk("i_rdy", DW'(bus.i_rdy), DW'(sb.size() != 2));
            chk("o_vld", DW'(bus.o_vld), DW'(sb.size() != 0));
            if (flush) begin
                sb.delete();
            end else begin
                if (bus.o_vld && bus.o_rdy && sb.size() != 0) begin
                    exp = sb.pop_front();
                    chk("o_dat", bus.o_dat, exp);
                end
                if (bus.i_vld && bus.i_rdy) sb.push_back(bus.i_dat);
            end
        end
    end

    a_cnt_max: assert property (@(posedge clk) disable iff (rst) bus.cnt <= 2'd2)
        else $error("FAIL assert cnt_max: cnt=%0d", bus.cnt);
    a_bp_stable: assert property (@(posedge clk) disable iff (rst)
        (bus.o_vld && !bus.o_rdy && !flush) |=> (bus.o_vld && $stable(bus.o_dat)))
        else $error("FAIL assert bp_stable: o_vld=%0b o_dat=0x%0h", bus.o_vld, bus.o_dat);

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        bus.i_vld = 1'b0;
        bus.i_dat = '0;
        bus.o_rdy = 1'b0;

        // Reset then idle
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        peek("rst_idle_dat", 0);

        // Streaming at full rate
        for (int i = 1; i <= 4; i++) cyc(0, 0, 1, DW'(i), 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);

        // Backpressure fill, then release: A, B, C in order
        cyc(0, 0, 1, 32'hA, 0);
        cyc(0, 0, 1, 32'hB, 0);
        cyc(0, 0, 1, 32'hC, 0);
        peek("bp_hold0", 32'hA);
        cyc(0, 0, 1, 32'hC, 0);
        peek("bp_hold1", 32'hA);
        cyc(0, 0, 1, 32'hC, 1);
        cyc(0, 0, 1, 32'hC, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);

        // Simultaneous enqueue/dequeue in BUSY
        cyc(0, 0, 1, 32'h5, 0);
        cyc(0, 0, 1, 32'h6, 1);
        peek("busy_swap", 32'h6);
        for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 1);

        // Flush while FULL with o_rdy high
        cyc(0, 0, 1, 32'h7, 0);
        cyc(0, 0, 1, 32'h8, 0);
        cyc(0, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);

        // Reset while FULL with i_vld high
        cyc(0, 0, 1, 32'h9, 0);
        cyc(0, 0, 1, 32'hA, 0);
        cyc(1, 0, 1, 32'hF, 0);
        peek("mid_rst_dat", 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);

        // Random traffic with occasional flush
        for (int i = 0; i < 400; i++)
            cyc(0, ($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0));

        // Drain and confirm everything accepted was delivered
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
        @(negedge clk);
        #2;
        chk("drain_cnt", DW'(bus.cnt), 0);
        chk("drain_sb", DW'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gnrl_skid_buf.md
Name: gnrl_skid_buf

Overview:
- Two-entry registered skid buffer for a valid/ready channel of DW-bit payload.
- Fully registers the forward path (o_vld, o_dat) and the backward path (i_rdy), so no combinational path exists from any input to any output.
- Placed at the downstream end of long valid/ready links, complementing the bypass buffers that cut only the ready path at the upstream end.
- Preserves order; never drops or duplicates data except on flush.

Parameters:
- DW, 32, payload width in bits (min 1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  synchronous discard of all buffered entries.
- i_vld  input  1  upstream valid.
- i_rdy  output  1  upstream ready; driven directly from a flop.
- i_dat  input  DW  upstream payload.
- o_vld  output  1  downstream valid; driven directly from a flop.
- o_rdy  input  1  downstream ready.
- o_dat  output  DW  downstream payload; driven directly from the main data register.
- cnt  output  2  occupancy, 0..2; driven from state.

Behaviour:
- Storage: main register (drives o_dat) and skid register. A transfer occurs on a cycle with vld & rdy high at the rising edge.
- States:
  - EMPTY: cnt=0, o_vld=0, i_rdy=1.
  - BUSY: cnt=1, o_vld=1, i_rdy=1.
  - FULL: cnt=2, o_vld=1, i_rdy=0.
- Reset:
  - State EMPTY; i_rdy=1, o_vld=0, cnt=0.
  - Main and skid data registers reset to 0.
  - Any i_vld during a reset cycle is ignored.
- Transitions (rst=0, flush=0):
  - EMPTY, i_vld=1: main<=i_dat; go BUSY. o_rdy is ignored because o_vld=0.
  - EMPTY, i_vld=0: stay EMPTY.
  - BUSY, i_vld=1, o_rdy=1: main<=i_dat; stay BUSY. Simultaneous enqueue and dequeue.
  - BUSY, i_vld=1, o_rdy=0: skid<=i_dat; go FULL.
  - BUSY, i_vld=0, o_rdy=1: go EMPTY.
  - BUSY, i_vld=0, o_rdy=0: hold.
  - FULL, o_rdy=1: main<=skid; go BUSY. i_vld is ignored because i_rdy=0.
  - FULL, o_rdy=0: hold all state.
- Flush:
  - Takes priority over all transitions: next state EMPTY, cnt=0.
  - Any input transfer or output transfer in the flush cycle is discarded and not counted.
  - i_rdy and o_vld are not gated combinationally by flush; both simply reflect state next cycle.
- rst has priority over flush.
- Latency:
  - Input to o_vld is 1 cycle minimum.
  - Sustained throughput is 1 transfer per cycle when o_rdy=1.
  - One stall cycle (o_rdy=0) with input pending fills the skid register; i_rdy drops the following cycle.
- Stability:
  - While o_vld=1 and o_rdy=0, o_dat holds stable.
  - Skid data is always older than any later input and is presented before it.
- Invariants:
  - cnt equals the number of accepted minus delivered entries.
  - i_rdy == (cnt!=2).
  - o_vld == (cnt!=0).
- DW affects only data registers; control logic is width-independent.
- Assertion targets for verification:
  - No combinational input-to-output path.
  - o_dat and o_vld are stable under backpressure.
  - cnt never exceeds 2.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release, no i_vld -> i_rdy=1, o_vld=0, cnt=0, o_dat=0.
- Streaming: o_rdy=1, i_vld=1 with data 0x1,0x2,0x3,0x4 on consecutive cycles -> o_vld=1 from the cycle after 0x1 is accepted, o_dat 0x1..0x4 on consecutive cycles, cnt stays 1, i_rdy never drops.
- Backpressure fill:
  - Stimulus: o_rdy=0, push 0xA then 0xB, then offer 0xC.
  - Before release: cnt=2, i_rdy=0, 0xC not accepted, o_dat=0xA stable.
  - Then raise o_rdy -> outputs 0xA, then 0xB after 0xC is accepted (i_rdy=1 one cycle after the first dequeue), then 0xC. Order is A, B, C.
- Simultaneous enqueue/dequeue in BUSY:
  - Setup: main=0x5, i_vld=1 with i_dat=0x6, o_rdy=1.
  - Response: 0x5 delivered, main=0x6, cnt stays 1.
- Flush while FULL:
  - Setup: entries 0x7, 0x8, then flush=1 with o_rdy=1 and i_vld=0.
  - Response: next cycle cnt=0, o_vld=0, i_rdy=1; 0x8 never appears; the flush-cycle o_rdy is not counted as a delivery.
- Reset mid-operation: FULL with 0x9, 0xA, assert rst for 1 cycle with i_vld=1 -> next cycle EMPTY, o_vld=0, o_dat=0, i_rdy=1; no stale data emitted afterward.
